aia_csr_resp: RTL and testbench

AIA_CSR_RESP -- requirements
Module: aia_csr_resp

---
 rtl/aia_csr_resp_if.sv | 24 ++
 rtl/aia_csr_resp.sv | 89 ++++++++
 tb/tb_aia_csr_resp.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aia_csr_resp_if.sv
// aia_csr_resp_if: CSR request/response channel between a requester and the AIA responder
interface aia_csr_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] aia_addr;
  logic [4:0]            aia_csr_imm;
  logic [REG_WIDTH-1:0]  aia_rs1_val;
  logic [2:0]            aia_funct3;
  logic [1:0]            aia_reg_op;
  logic                  aia_reg_en;
  logic                  aia_rrsp;
  logic [ADDR_WIDTH-1:0] aia_rdata;
  logic                  aia_rvalid;
  logic [2:0]            aia_act_rsp;
  modport master (
    output aia_addr, aia_csr_imm, aia_rs1_val, aia_funct3, aia_reg_op, aia_reg_en, aia_rrsp,
    input  aia_rdata, aia_rvalid, aia_act_rsp
  );
  modport slave (
    input  aia_addr, aia_csr_imm, aia_rs1_val, aia_funct3, aia_reg_op, aia_reg_en, aia_rrsp,
    output aia_rdata, aia_rvalid, aia_act_rsp
  );
endinterface

// File: rtl/aia_csr_resp.sv
// aia_csr_resp: AIA IMSIC-style CSR responder (miselect/mireg/mtopei) with a held response and meip output
module aia_csr_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  aia_csr_resp_if.slave       bus,
  input  logic [63:0]         ext_irq_set,
  output logic                meip
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0]  misel_q, misel_d;
  logic        dlv_q, dlv_d;
  logic [5:0]  thr_q, thr_d;
  logic [63:0] eip_q, eip_d, eie_q, eie_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  act_q, act_d;
  logic [5:0]  top;
  logic [31:0] src, old, newv, mtopei;
  logic        is_sel, is_ireg, is_top, sel_ok, bad_f3, exc, accept, we;
  always_comb begin
    top = '0;
    for (int i = 63; i >= 1; i--)
      if (eip_q[i] && eie_q[i] && (thr_q == '0 || 6'(i) < thr_q)) top = 6'(i);
    if (!dlv_q) top = '0;
  end
  assign mtopei = {5'b0, 11'(top), 5'b0, 11'(top)};
  assign meip   = top != '0;
  always_comb begin
    src     = 32'(bus.aia_funct3[2] ? REG_WIDTH'(bus.aia_csr_imm) : bus.aia_rs1_val);
    is_sel  = bus.aia_addr == ADDR_WIDTH'(12'h350);
    is_ireg = bus.aia_addr == ADDR_WIDTH'(12'h351);
    is_top  = bus.aia_addr == ADDR_WIDTH'(12'h35C);
    sel_ok  = misel_q inside {8'h70, 8'h72, 8'h80, 8'h81, 8'hC0, 8'hC1};
    bad_f3  = bus.aia_funct3[1:0] == 2'b00;
    exc     = bad_f3 || !(is_sel || is_top || (is_ireg && sel_ok));
    old     = is_sel ? {24'b0, misel_q} : is_top ? mtopei :
              misel_q == 8'h70 ? {31'b0, dlv_q} : misel_q == 8'h72 ? {26'b0, thr_q} :
              misel_q == 8'h80 ? eip_q[31:0] : misel_q == 8'h81 ? eip_q[63:32] :
              misel_q == 8'hC0 ? eie_q[31:0] : eie_q[63:32];
    newv    = bus.aia_funct3[1:0] == 2'b01 ? src : bus.aia_funct3[1:0] == 2'b10 ? old | src : old & ~src;
    accept  = state_q == IDLE && bus.aia_reg_en;
    we      = accept && bus.aia_reg_op[0] && !exc;
    state_d = accept ? RESP : (state_q == RESP && bus.aia_rrsp) ? IDLE : state_q;
    misel_d = misel_q;
    dlv_d   = dlv_q;
    thr_d   = thr_q;
    eip_d   = eip_q;
    eie_d   = eie_q;
    if (we && is_sel) misel_d = newv[7:0];
    if (we && is_ireg && misel_q == 8'h70) dlv_d = newv[0];
    if (we && is_ireg && misel_q == 8'h72) thr_d = newv[5:0];
    if (we && is_ireg && misel_q == 8'h80) eip_d[31:0] = {newv[31:1], 1'b0};
    if (we && is_ireg && misel_q == 8'h81) eip_d[63:32] = newv;
    if (we && is_ireg && misel_q == 8'hC0) eie_d[31:0] = {newv[31:1], 1'b0};
    if (we && is_ireg && misel_q == 8'hC1) eie_d[63:32] = newv;
    if (we && is_top) eip_d[top] = 1'b0;
    // external sets land after CSR writes so a coincident set beats a clear
    eip_d   = eip_d | (ext_irq_set & ~64'h1);
    rdata_d = accept ? ((bus.aia_reg_op[1] && !exc) ? old : 32'h0) : rdata_q;
    act_d   = accept ? (exc ? {1'b1, bad_f3 ? 2'b11 : 2'b01} : 3'b000) : act_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      misel_q <= '0;
      dlv_q   <= 1'b0;
      thr_q   <= '0;
      eip_q   <= '0;
      eie_q   <= '0;
      rdata_q <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      misel_q <= misel_d;
      dlv_q   <= dlv_d;
      thr_q   <= thr_d;
      eip_q   <= eip_d;
      eie_q   <= eie_d;
      rdata_q <= rdata_d;
      act_q   <= act_d;
    end
  end
  assign bus.aia_rvalid  = state_q == RESP;
  assign bus.aia_rdata   = bus.aia_rvalid ? ADDR_WIDTH'(rdata_q) : '0;
  assign bus.aia_act_rsp = bus.aia_rvalid ? act_q : 3'b000;
endmodule

// File: tb/tb_aia_csr_resp.sv
// tb_aia_csr_resp: randomized and directed checks of aia_csr_resp against a register-level model
module tb_aia_csr_resp;
  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] ext_irq_set = '0;
  logic meip;
  int n_tests = 0, n_fail = 0;
  aia_csr_resp_if #(.ADDR_WIDTH(32), .REG_WIDTH(32)) bus ();
  aia_csr_resp #(.ADDR_WIDTH(32), .REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ext_irq_set(ext_irq_set), .meip(meip));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] a; logic [2:0] f3; logic [4:0] imm; logic [31:0] rs1; logic [1:0] op; logic [63:0] set;
  } op_t;
  logic [7:0] m_sel; logic m_dlv; logic [5:0] m_thr; logic [63:0] m_eip, m_eie;
  function automatic op_t mk(input [31:0] a, input [2:0] f3, input [31:0] rs1, input [1:0] op, input [63:0] set);
    op_t o; o.a = a; o.f3 = f3; o.imm = 5'd0; o.rs1 = rs1; o.op = op; o.set = set; return o;
  endfunction
  function automatic void m_reset();
    m_sel = 0; m_dlv = 0; m_thr = 0; m_eip = 0; m_eie = 0;
  endfunction
  function automatic int m_top();
    if (!m_dlv) return 0;
    for (int i = 1; i < 64; i++)
      if (m_eip[i] && m_eie[i] && (m_thr == 0 || i < int'(m_thr))) return i;
    return 0;
  endfunction
  function automatic void m_access(input op_t o, output logic [31:0] rd, output logic [2:0] act);
    logic [31:0] s, v, n; bit ok; int t;
    s = o.f3[2] ? {27'b0, o.imm} : o.rs1;
    t = m_top(); ok = 1; v = 0;
    case (o.a)
      32'h350: v = {24'b0, m_sel};
      32'h35C: v = {5'b0, 11'(t), 5'b0, 11'(t)};
      32'h351: case (m_sel)
        8'h70: v = {31'b0, m_dlv};
        8'h72: v = {26'b0, m_thr};
        8'h80: v = m_eip[31:0];
        8'h81: v = m_eip[63:32];
        8'hC0: v = m_eie[31:0];
        8'hC1: v = m_eie[63:32];
        default: ok = 0;
      endcase
      default: ok = 0;
    endcase
    if (o.f3[1:0] == 2'b00) begin rd = 0; act = 3'b111; end
    else if (!ok) begin rd = 0; act = 3'b101; end
    else begin
      rd = o.op[1] ? v : 32'h0; act = 3'b000;
      case (o.f3[1:0]) 2'b01: n = s; 2'b10: n = v | s; default: n = v & ~s; endcase
      if (o.op[0]) case (o.a)
        32'h350: m_sel = n[7:0];
        32'h35C: if (t != 0) m_eip[t] = 1'b0;
        default: case (m_sel)
          8'h70: m_dlv = n[0];
          8'h72: m_thr = n[5:0];
          8'h80: m_eip[31:0] = {n[31:1], 1'b0};
          8'h81: m_eip[63:32] = n;
          8'hC0: m_eie[31:0] = {n[31:1], 1'b0};
          default: m_eie[63:32] = n;
        endcase
      endcase
    end
    m_eip = m_eip | (o.set & ~64'h1);
  endfunction
  task automatic issue(input op_t o, input int hold, input bit dup, output bit early, output bit v,
                       output logic [31:0] rd, output logic [2:0] act, output bit stable, output bit after);
    bus.aia_addr = o.a; bus.aia_funct3 = o.f3; bus.aia_csr_imm = o.imm; bus.aia_rs1_val = o.rs1;
    bus.aia_reg_op = o.op; bus.aia_reg_en = 1'b1; bus.aia_rrsp = 1'b0; ext_irq_set = o.set;
    #1 early = bus.aia_rvalid;
    @(posedge clk); #1;
    ext_irq_set = '0; bus.aia_reg_en = dup;
    if (dup) begin bus.aia_addr = 32'h350; bus.aia_funct3 = 3'b001; bus.aia_rs1_val = 32'hFF; bus.aia_reg_op = 2'b11; end
    v = bus.aia_rvalid; rd = bus.aia_rdata; act = bus.aia_act_rsp; stable = 1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.aia_rvalid !== 1'b1 || bus.aia_rdata !== rd || bus.aia_act_rsp !== act) stable = 0;
    end
    bus.aia_rrsp = 1'b1; bus.aia_reg_en = 1'b0;
    @(posedge clk); #1;
    bus.aia_rrsp = 1'b0; after = bus.aia_rvalid;
  endtask
  task automatic test_reset();
    bus.aia_addr = 0; bus.aia_funct3 = 0; bus.aia_csr_imm = 0; bus.aia_rs1_val = 0;
    bus.aia_reg_op = 0; bus.aia_reg_en = 1'b1; bus.aia_rrsp = 0; rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.aia_rvalid, bus.aia_rdata, bus.aia_act_rsp, meip} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got rvalid=%b rdata=%h act=%b meip=%b want all 0",
                         bus.aia_rvalid, bus.aia_rdata, bus.aia_act_rsp, meip);
    end
    bus.aia_reg_en = 1'b0; rst = 1'b0; m_reset();
  endtask
  task automatic test_indirect_rw();
    op_t t[3]; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    t[0] = mk(32'h350, 3'b001, 32'h80, 2'b11, 0);
    t[1] = mk(32'h351, 3'b010, 32'h6, 2'b11, 0);
    t[2] = mk(32'h351, 3'b010, 32'h0, 2'b10, 0);
    for (int i = 0; i < 3; i++) begin
      m_access(t[i], erd, eact);
      issue(t[i], 0, 0, e, v, rd, act, s, af);
      n_tests++;
      if (e !== 0 || v !== 1 || af !== 0 || rd !== erd || act !== eact) begin
        n_fail++; $display("FAIL indirect_rw[%0d] early=%b v=%b after=%b rd=%h act=%b want rd=%h act=%b",
                           i, e, v, af, rd, act, erd, eact);
      end
    end
    n_tests++;
    if (rd !== 32'h6) begin n_fail++; $display("FAIL eip0_read got %h want 00000006", rd); end
  endtask
  task automatic test_mtopei();
    op_t t[11]; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    logic [31:0] tops[11];
    t[0] = mk(32'h350, 3'b001, 32'h70, 2'b01, 0);  t[1] = mk(32'h351, 3'b001, 32'h1, 2'b01, 0);
    t[2] = mk(32'h350, 3'b001, 32'hC0, 2'b01, 0);  t[3] = mk(32'h351, 3'b001, 32'h6, 2'b01, 0);
    t[4] = mk(32'h350, 3'b001, 32'h72, 2'b01, 0);  t[5] = mk(32'h351, 3'b001, 32'h0, 2'b01, 0);
    t[6] = mk(32'h350, 3'b001, 32'h80, 2'b01, 0);  t[7] = mk(32'h351, 3'b001, 32'h6, 2'b01, 0);
    t[8] = mk(32'h35C, 3'b010, 32'h0, 2'b10, 0);   t[9] = mk(32'h35C, 3'b001, 32'hDEAD, 2'b01, 0);
    t[10] = mk(32'h35C, 3'b010, 32'h0, 2'b10, 0);
    for (int i = 0; i < 11; i++) begin
      m_access(t[i], erd, eact);
      issue(t[i], 0, 0, e, v, rd, act, s, af);
      tops[i] = rd;
      n_tests++;
      if (e !== 0 || v !== 1 || rd !== erd || act !== eact || meip !== (m_top() != 0)) begin
        n_fail++; $display("FAIL mtopei[%0d] v=%b rd=%h act=%b meip=%b want rd=%h act=%b meip=%b",
                           i, v, rd, act, meip, erd, eact, m_top() != 0);
      end
    end
    n_tests++;
    if (tops[8] !== 32'h00010001 || tops[10] !== 32'h00020002 || meip !== 1'b1) begin
      n_fail++; $display("FAIL mtopei_values got %h,%h meip=%b want 00010001,00020002 meip=1", tops[8], tops[10], meip);
    end
  endtask
  task automatic test_exceptions();
    op_t t[6]; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    logic [2:0] acts[6]; logic [31:0] rds[6];
    t[0] = mk(32'h360, 3'b001, 32'hFFFFFFFF, 2'b11, 0); t[1] = mk(32'h350, 3'b000, 32'hFF, 2'b11, 0);
    t[2] = mk(32'h350, 3'b001, 32'h71, 2'b01, 0);       t[3] = mk(32'h351, 3'b001, 32'hFFFF, 2'b11, 0);
    t[4] = mk(32'h350, 3'b001, 32'h80, 2'b01, 0);       t[5] = mk(32'h35C, 3'b010, 32'h0, 2'b10, 0);
    for (int i = 0; i < 6; i++) begin
      m_access(t[i], erd, eact);
      issue(t[i], 0, 0, e, v, rd, act, s, af);
      acts[i] = act; rds[i] = rd;
      n_tests++;
      if (v !== 1 || rd !== erd || act !== eact) begin
        n_fail++; $display("FAIL exc[%0d] rd=%h act=%b want rd=%h act=%b", i, rd, act, erd, eact);
      end
    end
    n_tests++;
    if (acts[0] !== 3'b101 || acts[1] !== 3'b111 || acts[3] !== 3'b101 || rds[0] !== 0 || rds[5] !== 32'h00020002) begin
      n_fail++; $display("FAIL exc_codes got act=%b,%b,%b rd0=%h top=%h want 101,111,101 0 00020002",
                         acts[0], acts[1], acts[3], rds[0], rds[5]);
    end
  endtask
  task automatic test_stall();
    op_t o; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    o = mk(32'h35C, 3'b010, 32'h0, 2'b10, 0);
    m_access(o, erd, eact);
    issue(o, 5, 1, e, v, rd, act, s, af);
    n_tests++;
    if (v !== 1 || s !== 1 || af !== 0 || rd !== erd || act !== eact) begin
      n_fail++; $display("FAIL stall v=%b stable=%b after=%b rd=%h act=%b want rd=%h act=%b", v, s, af, rd, act, erd, eact);
    end
    o = mk(32'h350, 3'b010, 32'h0, 2'b10, 0);
    m_access(o, erd, eact);
    issue(o, 0, 0, e, v, rd, act, s, af);
    n_tests++;
    if (e !== 0 || rd !== erd || rd !== 32'h80) begin
      n_fail++; $display("FAIL stall_dup_ignored early=%b miselect=%h want 00000080", e, rd);
    end
  endtask
  task automatic test_set_vs_clear();
    op_t t[4]; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    t[0] = mk(32'h350, 3'b001, 32'h80, 2'b01, 0);  t[1] = mk(32'h351, 3'b010, 32'h4, 2'b01, 0);
    t[2] = mk(32'h351, 3'b011, 32'h4, 2'b01, 64'h4); t[3] = mk(32'h351, 3'b010, 32'h0, 2'b10, 0);
    for (int i = 0; i < 4; i++) begin
      m_access(t[i], erd, eact);
      issue(t[i], 0, 0, e, v, rd, act, s, af);
      n_tests++;
      if (v !== 1 || rd !== erd || act !== eact) begin
        n_fail++; $display("FAIL set_clear[%0d] rd=%h act=%b want rd=%h act=%b", i, rd, act, erd, eact);
      end
    end
    n_tests++;
    if (rd[2] !== 1'b1) begin n_fail++; $display("FAIL set_wins eip0=%h want bit2 set", rd); end
  endtask
  task automatic test_random();
    op_t o; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    logic [31:0] apool[6]; logic [7:0] spool[7];
    apool = '{32'h350, 32'h351, 32'h351, 32'h351, 32'h35C, 32'h360};
    spool = '{8'h70, 8'h72, 8'h80, 8'h81, 8'hC0, 8'hC1, 8'h71};
    for (int i = 0; i < 300; i++) begin
      o.a = apool[$urandom_range(0, 5)];
      o.f3 = 3'($urandom_range(0, 7)); o.imm = 5'($urandom); o.op = 2'($urandom_range(0, 3));
      o.rs1 = (o.a == 32'h350) ? {24'b0, spool[$urandom_range(0, 6)]} : $urandom;
      if (o.a == 32'h350 && $urandom_range(0, 2) != 0) o.f3 = 3'b001;
      o.set = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} : 64'h0;
      m_access(o, erd, eact);
      issue(o, $urandom_range(0, 2), 1'($urandom_range(0, 1)), e, v, rd, act, s, af);
      n_tests++;
      if (e !== 0 || v !== 1 || s !== 1 || af !== 0 || rd !== erd || act !== eact || meip !== (m_top() != 0)) begin
        n_fail++; $display("FAIL random[%0d] a=%h f3=%b op=%b v=%b st=%b rd=%h act=%b meip=%b want rd=%h act=%b meip=%b",
                           i, o.a, o.f3, o.op, v, s, rd, act, meip, erd, eact, m_top() != 0);
      end
    end
  endtask
  task automatic test_reset_mid_resp();
    op_t t[8]; op_t o; logic [31:0] erd, rd; logic [2:0] eact, act; bit e, v, s, af;
    t[0] = mk(32'h350, 3'b001, 32'h70, 2'b01, 0); t[1] = mk(32'h351, 3'b001, 32'h1, 2'b01, 0);
    t[2] = mk(32'h350, 3'b001, 32'h72, 2'b01, 0); t[3] = mk(32'h351, 3'b001, 32'h0, 2'b01, 0);
    t[4] = mk(32'h350, 3'b001, 32'hC1, 2'b01, 0); t[5] = mk(32'h351, 3'b001, 32'hFFFFFFFF, 2'b01, 0);
    t[6] = mk(32'h350, 3'b001, 32'h81, 2'b01, 0); t[7] = mk(32'h351, 3'b001, 32'hFFFFFFFF, 2'b01, 0);
    for (int i = 0; i < 8; i++) begin m_access(t[i], erd, eact); issue(t[i], 0, 0, e, v, rd, act, s, af); end
    n_tests++;
    if (meip !== 1'b1) begin n_fail++; $display("FAIL pre_reset_meip got %b want 1", meip); end
    bus.aia_addr = 32'h350; bus.aia_funct3 = 3'b010; bus.aia_rs1_val = 0; bus.aia_reg_op = 2'b10;
    bus.aia_reg_en = 1'b1; bus.aia_rrsp = 1'b0;
    @(posedge clk); #1 bus.aia_reg_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.aia_rvalid, bus.aia_rdata, bus.aia_act_rsp, meip} !== '0) begin
      n_fail++; $display("FAIL mid_resp_reset rvalid=%b rdata=%h act=%b meip=%b want all 0",
                         bus.aia_rvalid, bus.aia_rdata, bus.aia_act_rsp, meip);
    end
    @(negedge clk) rst = 1'b0; m_reset();
    @(negedge clk);
    n_tests++;
    if (bus.aia_rvalid !== 1'b0) begin n_fail++; $display("FAIL no_retry rvalid=%b want 0", bus.aia_rvalid); end
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: o = mk(32'h350, 3'b010, 0, 2'b10, 0);
        13: o = mk(32'h35C, 3'b010, 0, 2'b10, 0);
        default: o = (i % 2 == 1) ? mk(32'h350, 3'b001, {24'b0, t[0].rs1[7:0] == 0 ? 8'h0 :
                   (i == 1 ? 8'h70 : i == 3 ? 8'h72 : i == 5 ? 8'h80 : i == 7 ? 8'h81 : i == 9 ? 8'hC0 : 8'hC1)}, 2'b01, 0)
                   : mk(32'h351, 3'b010, 0, 2'b10, 0);
      endcase
      m_access(o, erd, eact);
      issue(o, 0, 0, e, v, rd, act, s, af);
      n_tests++;
      if (v !== 1 || rd !== erd || act !== eact || (o.op[1] && rd !== 0)) begin
        n_fail++; $display("FAIL post_reset[%0d] a=%h rd=%h act=%b want rd=%h act=%b", i, o.a, rd, act, erd, eact);
      end
    end
  endtask
  initial begin
    test_reset();
    test_indirect_rw();
    test_mtopei();
    test_exceptions();
    test_stall();
    test_set_vs_clear();
    test_random();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
